// File: rtl/array_alu_apb_arb.sv
// Two-requester round-robin arbiter driving a single APB master port.
// One transfer in flight; completion is a registered one-cycle pulse.
module array_alu_apb_arb #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                aresetn,
   input  logic [1:0]          req,
   output logic [1:0]          gnt,
   input  logic [2*ADDR_W-1:0] addr,
   input  logic [1:0]          write,
   input  logic [2*DATA_W-1:0] wdata,
   output logic [1:0]          rsp,
   output logic [DATA_W-1:0]   rdata,
   output logic                err,
   output logic [ADDR_W-1:0]   paddr,
   output logic                psel,
   output logic                penable,
   output logic                pwrite,
   output logic [DATA_W-1:0]   pwdata,
   input  logic                pready,
   input  logic [DATA_W-1:0]   prdata,
   input  logic                pslverr
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t            state;
   state_t            nxt;
   logic              lp;
   logic              win;
   logic              grant;
   logic              done;
   logic              tmo;
   logic [CW-1:0]     cnt;
   logic [ADDR_W-1:0] cap_addr;
   logic [DATA_W-1:0] cap_wdata;
   logic              cap_write;
   logic              cap_w;
   logic [1:0]        rsp_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;

   // Prefer the requester that did not win last time.
   always_comb begin
      win   = req[~lp] ? ~lp : lp;
      grant = (state == IDLE) && (req != 2'b00);
      done  = (state == ACCESS) && pready;
      tmo   = (TIMEOUT != 0) && (state == ACCESS) && !pready
              && (cnt == CW'(TIMEOUT - 1));
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (grant) nxt = SETUP;
         SETUP:   nxt = ACCESS;
         ACCESS:  if (done || tmo) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt     = 2'b00;
      psel    = 1'b0;
      penable = 1'b0;
      unique case (state)
         IDLE:    if (grant && aresetn) gnt = {win, ~win};
         SETUP:   psel = 1'b1;
         ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         lp        <= 1'b1;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_write <= 1'b0;
         cap_w     <= 1'b0;
      end else if (grant) begin
         lp        <= win;
         cap_w     <= win;
         cap_write <= write[win];
         cap_addr  <= win ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
         cap_wdata <= win ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
      end
   end

   // Wait-state counter, restarted every time ACCESS is entered.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         cnt <= '0;
      end else if (state == SETUP) begin
         cnt <= '0;
      end else if ((state == ACCESS) && !pready) begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         rsp_q   <= 2'b00;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (done || tmo) begin
         rsp_q   <= {cap_w, ~cap_w};
         err_q   <= tmo | pslverr;
         rdata_q <= (tmo || cap_write) ? '0 : prdata;
      end else begin
         rsp_q   <= 2'b00;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end
   end

   assign rsp    = rsp_q;
   assign rdata  = rdata_q;
   assign err    = err_q;
   assign paddr  = cap_addr;
   assign pwrite = cap_write;
   assign pwdata = cap_wdata;

endmodule

// File: doc/array_alu_apb_arb.md
ARRAY_ALU_APB_ARB -- requirements
Module: array_alu_apb_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB/requester address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB/requester data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, max ACCESS cycles awaiting pready; 0 disables the timeout.
REQ-004 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-005 SHALL have port aresetn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  in  2  per-requester transfer request; bit i = requester i.
REQ-007 SHALL have port gnt  out  2  one-cycle accept pulse; at most one bit set.
REQ-008 SHALL have port addr  in  2*ADDR_W  packed addresses; slice i for requester i.
REQ-009 SHALL have port write  in  2  per-requester direction: 1 write, 0 read.
REQ-010 SHALL have port wdata  in  2*DATA_W  packed write data; slice i for requester i.
REQ-011 SHALL have port rsp  out  2  one-cycle completion pulse to the owning requester.
REQ-012 SHALL have port rdata  out  DATA_W  read data; valid only while any rsp bit is 1.
REQ-013 SHALL have port err  out  1  completion error; valid only while any rsp bit is 1.
REQ-014 SHALL have APB master ports paddr out ADDR_W, psel out 1, penable out 1, pwrite out 1, pwdata out DATA_W, pready in 1, prdata in DATA_W, pslverr in 1, connected to array_alu.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACCESS; reset state IDLE.
REQ-016 In IDLE with req != 0, SHALL assert gnt[w] combinationally for the winner w, capture addr/write/wdata slice w into registers, and go to SETUP next cycle.
REQ-017 Arbitration SHALL be round-robin: last-granted pointer lp; winner = !lp if req[!lp], else lp if req[lp]; lp <= w on grant; lp resets to 1, so requester 0 wins the first tie.
REQ-018 SETUP: psel=1, penable=0; unconditionally go to ACCESS.
REQ-019 ACCESS: psel=1, penable=1; on a clock edge with pready=1, go to IDLE and on the next cycle pulse rsp[w]=1 with rdata=prdata (0 for writes), err=pslverr.
REQ-020 paddr, pwrite, pwdata SHALL come from capture registers, stay stable from SETUP through the end of ACCESS, and hold their values in IDLE.
REQ-021 Timeout: a counter SHALL clear on entering ACCESS and increment each ACCESS cycle with pready=0; when TIMEOUT!=0 and the count reaches TIMEOUT, SHALL go to IDLE (psel/penable low next cycle) and pulse rsp[w] with err=1, rdata=0.
REQ-022 Latency SHALL be: gnt in cycle N, SETUP N+1, ACCESS N+2, rsp N+3 for zero-wait pready; each pready wait cycle adds one.
REQ-023 The rsp cycle is IDLE, so a new grant SHALL be allowed in the same cycle as rsp, giving 3-cycle back-to-back throughput.
REQ-024 Request deasserted before gnt SHALL be dropped with no APB activity; req held after gnt SHALL be treated as a new request.
REQ-025 gnt SHALL be 0 outside IDLE; rsp, err, rdata SHALL be 0 when no completion is pending.
REQ-026 pslverr/prdata SHALL be ignored except on the completing ACCESS edge.

Reset
REQ-027 On aresetn=0, immediately and asynchronously: state=IDLE, lp=1, timeout count=0, capture registers=0, and all outputs 0 (gnt, rsp, rdata, err, paddr, psel, penable, pwrite, pwdata).
REQ-028 A transfer aborted by reset SHALL produce no rsp; after release, the first IDLE cycle with req set SHALL grant normally.

Verification
REQ-029 Single read: req=2'b01, addr0=0x10, pready=1 at first ACCESS, prdata=0xCAFE -> gnt=01 at N, psel N+1..N+2, penable N+2, rsp=01 at N+3, rdata=0xCAFE, err=0.
REQ-030 Contention: req=2'b11 held for 4 transfers -> grant order 0,1,0,1; transfers back-to-back, 3 cycles apart.
REQ-031 Wait states + error: write with pready low 3 ACCESS cycles, then pready=1, pslverr=1 -> paddr/pwdata stable throughout, rsp at completion+1, err=1, rdata=0.
REQ-032 Timeout: TIMEOUT=4, pready stuck 0 -> 4 ACCESS cycles, psel drops, rsp with err=1, rdata=0; next request still served.
REQ-033 Reset mid-ACCESS: assert aresetn=0 during ACCESS for 100 clk, then release -> psel/penable 0 immediately, no rsp, lp=1; next req=2'b11 grants requester 0.
